// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM for a shared-memory datapath.
// Memory wait states are bounded by MEM_TIMEOUT and report sticky error flags.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_t;

    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t          state_q;
    state_t          state_nxt;
    state_t          dec_target;
    logic [CW-1:0]   wait_cnt;
    logic            in_wait;
    logic            timeout;
    logic            dec_illegal;

    // Unsupported opcodes map to FETCH; no legal opcode ever decodes there.
    function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_LW, OP_SW:                      return S_MEM_ADDR;
            OP_RTYPE:                          return (fn == FN_JR) ? S_JR : S_R_EXEC;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_I_EXEC;
            OP_BEQ, OP_BNE:                    return S_BRANCH;
            OP_J:                              return S_JUMP;
            OP_JAL:                            return S_JAL;
            default:                           return S_FETCH;
        endcase
    endfunction

    assign dec_target  = decode_target(opcode, funct);
    assign in_wait     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout     = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);
    assign dec_illegal = (state_q == S_DECODE) && (dec_target == S_FETCH);
    assign state       = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            // A timeout re-enters FETCH, so the retry starts a fresh wait window.
            if ((state_nxt != state_q) || timeout) begin
                wait_cnt <= '0;
            end else if (in_wait && !mem_ready && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (dec_illegal) begin
                illegal_op <= 1'b1;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state_q)
            S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_nxt = dec_target;
            S_MEM_ADDR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_nxt = mem_ready ? S_MEM_WB : (timeout ? S_FETCH : S_MEM_RD);
            S_MEM_WR:   state_nxt = (mem_ready || timeout) ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   state_nxt = S_R_WB;
            S_I_EXEC:   state_nxt = S_I_WB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b111;
        PCSource    = 2'b00;
        RegWrite    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b000;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 3'b000;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 3'b000;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = !timeout;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b001;
            end
            S_R_WB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_ANDI: ALUOp = 3'b010;
                    OP_ORI:  ALUOp = 3'b011;
                    OP_SLTI: ALUOp = 3'b110;
                    default: ALUOp = 3'b000;
                endcase
            end
            S_I_WB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                BranchNe    = (opcode == OP_BNE);
                ALUOp       = (opcode == OP_BNE) ? 3'b101 : 3'b100;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
            end
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
            end
            default: ;
        endcase
        // Reset must abort any in-flight instruction without architectural side effects.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
            MemRead     = 1'b0;
        end
    end

endmodule
